// File: rtl/tff_ctrl_pkg.sv
// rtl/tff_ctrl_pkg.sv - shared types and constants for the T-flip-flop counter controller
//
// Purpose : FSM state encoding and default counter width used by tff_count_ctrl.
// Contents: TFF_DEFAULT_WIDTH - default bank width
//           tff_state_e       - controller states IDLE / RUN / PAUSE
package tff_ctrl_pkg;

  localparam int TFF_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } tff_state_e;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop cell with synchronous set/clear
//
// Purpose: one bit of the counter bank. Q flips on a clock edge when T is high.
//          Set/Clear force Q synchronously and take priority over T.
// Ports  : Clock - rising-edge clock
//          Reset - asynchronous active-low reset, clears Q
//          T     - toggle enable
//          Set   - synchronous set (wins over Clear and T)
//          Clear - synchronous clear (wins over T)
//          Q     - cell state
module tff_cell (
  input  logic Clock,
  input  logic Reset,
  input  logic T,
  input  logic Set,
  input  logic Clear,
  output logic Q
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Q <= 1'b0;
    end else if (Set) begin
      Q <= 1'b1;
    end else if (Clear) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - modulo counter built from a bank of T flip-flops with run/pause control
//
// Purpose : WIDTH tff_cell instances form a counter running 0..Modulus. A small
//           IDLE/RUN/PAUSE FSM decides when the bank steps; Load presets the bank
//           while not running. Optional down-counting is compiled in with the
//           macro TFF_CTRL_DOWN_EN (without it Dir is ignored).
// Ports   : Clock   - rising-edge clock
//           Reset   - asynchronous active-low reset
//           Start   - level, begin/resume counting
//           Stop    - level, pause counting (wins over Start)
//           OneShot - latched on entry to RUN; stop after the first wrap
//           Load    - preset request, honoured in IDLE/PAUSE only
//           LoadVal - preset value, clamped to Modulus
//           Modulus - terminal count
//           Dir     - 0 up, 1 down (TFF_CTRL_DOWN_EN builds only)
//           Count   - bank state
//           Toggle  - per-cell T enables this cycle
//           Busy    - registered, high in RUN
//           Wrap    - registered pulse, count wrapped on the last edge
//           Done    - registered pulse, a one-shot run ended on the last edge
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = TFF_DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             OneShot,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] Modulus,
  input  logic             Dir,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] Toggle,
  output logic             Busy,
  output logic             Wrap,
  output logic             Done
);

  tff_state_e       state;
  logic             oneshot_q;

  logic             step_en;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] up_t;
  logic             up_c;
  logic [WIDTH-1:0] step_t;
  logic             step_wrap;
  logic             wrap_now;

  // Stop in RUN suppresses the step on the same edge, so a pause freezes
  // the value that was visible when Stop was sampled.
  assign step_en = (state == RUN) && !Stop;
  assign load_en = (state != RUN) && Load;
  assign load_val = (LoadVal > Modulus) ? Modulus : LoadVal;

  // Ripple-carry toggle pattern of a binary incrementer: cell i flips when
  // every lower cell is 1.
  always_comb begin
    up_t = '0;
    up_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = up_c;
      up_c    = up_c & Count[i];
    end
  end

`ifdef TFF_CTRL_DOWN_EN
  logic [WIDTH-1:0] dn_t;
  logic             dn_c;

  // Decrementer pattern: cell i flips when every lower cell is 0.
  always_comb begin
    dn_t = '0;
    dn_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      dn_t[i] = dn_c;
      dn_c    = dn_c & ~Count[i];
    end
  end

  // Wrap is detected only on exact equality with the terminal value. A count
  // that sits above a freshly lowered Modulus therefore rolls through
  // all-ones (or down to 0) as a plain binary step, without a Wrap pulse.
  always_comb begin
    step_t    = '0;
    step_wrap = 1'b0;
    if (Dir) begin
      step_wrap = (Count == '0);
      if (step_wrap) begin
        // A one-shot run finishes parked at 0 instead of reloading Modulus.
        step_t = oneshot_q ? '0 : (Count ^ Modulus);
      end else begin
        step_t = dn_t;
      end
    end else begin
      step_wrap = (Count == Modulus);
      step_t    = step_wrap ? Count : up_t;
    end
  end
`else
  logic unused_dir;
  assign unused_dir = Dir;

  // Toggling exactly the set bits clears the bank back to 0 at the top.
  always_comb begin
    step_wrap = (Count == Modulus);
    step_t    = step_wrap ? Count : up_t;
  end
`endif

  assign Toggle   = step_en ? step_t : '0;
  assign wrap_now = step_en && step_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .Clock (Clock),
        .Reset (Reset),
        .T     (Toggle[gi]),
        .Set   (load_en &  load_val[gi]),
        .Clear (load_en & ~load_val[gi]),
        .Q     (Count[gi])
      );
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      oneshot_q <= 1'b0;
      Busy      <= 1'b0;
      Wrap      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Wrap <= wrap_now;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Stop) begin
            state     <= RUN;
            oneshot_q <= OneShot;
            Busy      <= 1'b1;
          end
        end
        RUN: begin
          if (Stop) begin
            state <= PAUSE;
            Busy  <= 1'b0;
          end else if (wrap_now && oneshot_q) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        PAUSE: begin
          // With both levels high Stop wins and the pause simply holds.
          if (Stop && !Start) begin
            state <= IDLE;
          end else if (Start && !Stop) begin
            state     <= RUN;
            oneshot_q <= OneShot;
            Busy      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
